// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: MENU/PLAYING/WON/LOST sequencer tracking health, score and combo.
// Define GAME_FLOW_REGEN_EN to enable health regen on long slice streaks.
module game_flow_ctrl #(
  parameter int MAX_HEALTH       = 8,
  parameter int HIT_DAMAGE       = 2,
  parameter int MISS_DAMAGE      = 1,
  parameter int POINTS_PER_SLICE = 10,
  parameter int MAX_COMBO        = 7
`ifdef GAME_FLOW_REGEN_EN
  , parameter int REGEN_SLICES   = 16
`endif
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_btn,
  input  logic        block_sliced,
  input  logic        player_hit_by_obstacle,
  input  logic        block_missed,
  input  logic [17:0] curr_time,
  input  logic [17:0] max_time,
  output logic [1:0]  state,
  output logic [3:0]  health_out,
  output logic [11:0] score_out,
  output logic [2:0]  combo_out,
  output logic        timer_run_out,
  output logic        timer_clr_out,
  output logic        game_over_out
);
  typedef enum logic [1:0] {MENU = 2'd0, PLAYING = 2'd1, WON = 2'd2, LOST = 2'd3} state_t;
  state_t st, n_st;
  logic [3:0]  n_health, hp_dmg, hp;
  logic [11:0] n_score;
  logic [2:0]  n_combo, combo_inc;
  logic        n_clr, n_over, dmg_any;
  logic [4:0]  dmg;
  logic [12:0] sum;
  assign dmg_any   = player_hit_by_obstacle | block_missed;
  assign dmg       = 5'(player_hit_by_obstacle ? HIT_DAMAGE : 0) + 5'(block_missed ? MISS_DAMAGE : 0);
  assign hp_dmg    = (5'(health_out) > dmg) ? 4'(5'(health_out) - dmg) : 4'd0;
  assign sum       = 13'(score_out) + (block_sliced ? 13'(POINTS_PER_SLICE) * (13'(combo_out) + 13'd1) : 13'd0);
  assign combo_inc = (combo_out == 3'(MAX_COMBO)) ? combo_out : combo_out + 3'd1;
`ifdef GAME_FLOW_REGEN_EN
  localparam int SW = $clog2(REGEN_SLICES + 1);
  logic [SW-1:0] streak, n_streak;
  logic          wrap;
  // a regen is dropped whenever damage lands in the same cycle
  assign wrap = block_sliced && !dmg_any && (streak == SW'(REGEN_SLICES - 1));
  assign hp   = (wrap && health_out < 4'(MAX_HEALTH)) ? health_out + 4'd1 : hp_dmg;
`else
  assign hp = hp_dmg;
`endif
  always_comb begin
    n_st     = st;
    n_health = health_out;
    n_score  = score_out;
    n_combo  = combo_out;
    n_clr    = 1'b0;
    n_over   = 1'b0;
`ifdef GAME_FLOW_REGEN_EN
    n_streak = streak;
`endif
    case (st)
      MENU: if (start_btn) begin
        n_st     = PLAYING;
        n_health = 4'(MAX_HEALTH);
        n_score  = '0;
        n_combo  = '0;
        n_clr    = 1'b1;
`ifdef GAME_FLOW_REGEN_EN
        n_streak = '0;
`endif
      end
      PLAYING: begin
        n_health = hp;
        n_score  = sum[12] ? 12'hfff : sum[11:0];
        n_combo  = dmg_any ? 3'd0 : block_sliced ? combo_inc : combo_out;
`ifdef GAME_FLOW_REGEN_EN
        n_streak = (dmg_any || wrap) ? '0 : block_sliced ? streak + 1'b1 : streak;
`endif
        n_st     = (hp == 4'd0) ? LOST : (curr_time >= max_time) ? WON : PLAYING;
        n_over   = hp == 4'd0 || curr_time >= max_time;
      end
      default: n_st = start_btn ? MENU : st;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st            <= MENU;
      health_out    <= '0;
      score_out     <= '0;
      combo_out     <= '0;
      timer_run_out <= 1'b0;
      timer_clr_out <= 1'b0;
      game_over_out <= 1'b0;
`ifdef GAME_FLOW_REGEN_EN
      streak        <= '0;
`endif
    end else begin
      st            <= n_st;
      health_out    <= n_health;
      score_out     <= n_score;
      combo_out     <= n_combo;
      timer_run_out <= n_st == PLAYING;
      timer_clr_out <= n_clr;
      game_over_out <= n_over;
`ifdef GAME_FLOW_REGEN_EN
      streak        <= n_streak;
`endif
    end
  end
  assign state = st;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed test-plan steps plus random play against a behavioural model.
module tb_game_flow_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, sl, hit, miss;
  logic [17:0] ct, mt;
  logic [1:0]  state;
  logic [3:0]  health;
  logic [11:0] score;
  logic [2:0]  combo;
  logic        run, clr, over;
  int checks = 0, failures = 0;
  int m_st, m_hp, m_sc, m_cb, m_run, m_clr, m_go, m_strk;
  int exp_scores [9] = '{10, 30, 60, 100, 150, 210, 280, 360, 440};

  always #5 clk = ~clk;

  game_flow_ctrl dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_btn(start), .block_sliced(sl),
    .player_hit_by_obstacle(hit), .block_missed(miss), .curr_time(ct), .max_time(mt),
    .state(state), .health_out(health), .score_out(score), .combo_out(combo),
    .timer_run_out(run), .timer_clr_out(clr), .game_over_out(over)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), m_st);
    chk("health", 32'(health), m_hp);
    chk("score", 32'(score), m_sc);
    chk("combo", 32'(combo), m_cb);
    chk("timer_run", 32'(run), m_run);
    chk("timer_clr", 32'(clr), m_clr);
    chk("game_over", 32'(over), m_go);
  endtask

  task automatic model_reset();
    {m_st, m_hp, m_sc, m_cb, m_run, m_clr, m_go, m_strk} = '0;
  endtask

  // Game rules in plain integer arithmetic; evaluated with the inputs present at the edge.
  task automatic model_step();
    int nst, d;
    bit regen;
    nst = m_st; m_clr = 0; m_go = 0; regen = 0;
    if (m_st == 0) begin
      if (start) begin nst = 1; m_hp = 8; m_sc = 0; m_cb = 0; m_clr = 1; m_strk = 0; end
    end else if (m_st == 1) begin
      d = 2 * int'(hit) + int'(miss);
      if (sl) m_sc = (m_sc + 10 * (m_cb + 1) > 4095) ? 4095 : m_sc + 10 * (m_cb + 1);
      if (hit || miss) m_cb = 0;
      else if (sl) m_cb = (m_cb < 7) ? m_cb + 1 : 7;
`ifdef GAME_FLOW_REGEN_EN
      if (hit || miss) m_strk = 0;
      else if (sl) begin
        m_strk++;
        if (m_strk == 16) begin m_strk = 0; regen = 1; end
      end
`endif
      m_hp = (m_hp - d < 0) ? 0 : m_hp - d;
      if (regen && m_hp < 8) m_hp++;
      if (m_hp == 0) begin nst = 3; m_go = 1; end
      else if (ct >= mt) begin nst = 2; m_go = 1; end
    end else if (start) nst = 0;
    m_st = nst;
    m_run = (nst == 1) ? 1 : 0;
  endtask

  task automatic step(input bit s, input bit a, input bit h, input bit m);
    start = s; sl = a; hit = h; miss = m;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    {start, sl, hit, miss} = '0;
  endtask

  initial begin
    rst_n = 1'b0; {start, sl, hit, miss} = '0; ct = '0; mt = 18'd1000;
    model_reset();
    #12;
    check_all();
    @(negedge clk) rst_n = 1'b1;

    // game start
    step(1, 0, 0, 0);
    chk("start_state", 32'(state), 1);
    chk("start_health", 32'(health), 8);
    chk("start_clr", 32'(clr), 1);
    chk("start_run", 32'(run), 1);
    step(1, 0, 0, 0);
    chk("clr_one_cycle", 32'(clr), 0);
    chk("start_ignored", 32'(state), 1);

    // slice combo ramp
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 0, 0);
      chk("slice_score", 32'(score), exp_scores[i]);
    end
    chk("combo_sat", 32'(combo), 7);

    // fresh game for slice+miss with combo 3
    rst_n = 1'b0; #1; model_reset(); @(negedge clk) rst_n = 1'b1;
    step(1, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    chk("combo3", 32'(combo), 3);
    step(0, 1, 0, 1);
    chk("sm_score", 32'(score), 100);
    chk("sm_combo", 32'(combo), 0);
    chk("sm_health", 32'(health), 7);

    // four hits to LOST
    rst_n = 1'b0; #1; model_reset(); @(negedge clk) rst_n = 1'b1;
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      chk("hit_health", 32'(health), 6 - 2 * i);
    end
    chk("lost_state", 32'(state), 3);
    chk("lost_over", 32'(over), 1);
    chk("lost_run", 32'(run), 0);
    step(0, 1, 1, 1);
    chk("over_once", 32'(over), 0);
    chk("frozen_score", 32'(score), 0);
    step(1, 0, 0, 0);
    chk("back_menu", 32'(state), 0);

    // timeout win with health 1, then miss on the final tick
    for (int k = 0; k < 2; k++) begin
      ct = 0; mt = 100;
      step(1, 0, 0, 0);
      repeat (3) step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      chk("health1", 32'(health), 1);
      for (int t = 96; t <= 100; t++) begin
        ct = 18'(t);
        step(0, 0, 0, (k == 1 && t == 100));
      end
      chk("timeout_state", 32'(state), k == 0 ? 2 : 3);
      chk("timeout_over", 32'(over), 1);
      step(1, 0, 0, 0);
    end

    // max_time of zero wins on the first playing cycle
    ct = 0; mt = 0;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("mt0_won", 32'(state), 2);

    // asynchronous reset mid-game
    step(1, 0, 0, 0);
    mt = 1000;
    step(1, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk) rst_n = 1'b1;

    // random play
    ct = 0;
    for (int i = 0; i < 4000; i++) begin
      if (m_st == 0) mt = 18'($urandom_range(0, 300));
      step($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0);
      if (m_clr == 1) ct = 0;
      else if (m_run == 1) ct = ct + 18'd1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
